// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths and helpers for the 2.5-D convolution stream
//
// Purpose: datapath widths, tap/buffer geometry helpers and the pixel x tap
// multiply shared by conv_window_buffer and conv_25d_stream.
// Ports: none (package).

package conv_pkg;

  localparam int PIXEL_W = 8;
  localparam int TAP_W   = 8;
  localparam int PROD_W  = 17;
  localparam int ACC_W   = 32;

  // Bit offset of tap (k,z,ky,kx) inside the flattened kernel vector.
  function automatic int tap_offset(input int k, input int z, input int ky, input int kx,
                                    input int z_depth, input int ksize);
    return ((k * z_depth + z) * ksize * ksize + ky * ksize + kx) * TAP_W;
  endfunction

  // Entries per channel needed to hold KSIZE rows' worth of sliding window.
  function automatic int buffer_len(input int ksize, input int img_width);
    return (ksize - 1) * img_width + ksize;
  endfunction

  // Unsigned pixel times signed tap; the exact product always fits PROD_W bits.
  function automatic logic signed [PROD_W-1:0] pix_tap_mul(input logic [PIXEL_W-1:0] pix,
                                                           input logic [TAP_W-1:0] tap);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = {{(PROD_W - PIXEL_W){1'b0}}, pix};
    b = {{(PROD_W - TAP_W){tap[TAP_W-1]}}, tap};
    return a * b;
  endfunction

endpackage

// File: rtl/conv_window_buffer.sv
// rtl/conv_window_buffer.sv - per-channel sliding window and raster position tracking
//
// Purpose: shifts accepted pixels into a per-channel line buffer, tracks
// row/col and stride phase, and flags which accepted pixels complete an
// emitted window (and the frame's final one).
// Ports:
//   clock, reset           rising-edge clock, async active-low reset
//   in_valid               pixel_vector_in accepted at this edge
//   pixel_vector_in        Z_DEPTH unsigned pixels, channel z at [z*8 +: 8]
//   window_valid           window holds a window to be computed (registered)
//   window_last            that window is the frame's last emitted one
//   window                 pixel (z,ky,kx) at [((z*KSIZE+ky)*KSIZE+kx)*8 +: 8]

module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int KSIZE      = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int Z_DEPTH    = 4,
  parameter int STRIDE     = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [PIXEL_W*Z_DEPTH-1:0]            pixel_vector_in,
  output logic                                  window_valid,
  output logic                                  window_last,
  output logic [PIXEL_W*Z_DEPTH*KSIZE*KSIZE-1:0] window
);

  localparam int BUF_LEN  = buffer_len(KSIZE, IMG_WIDTH);
  localparam int COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int PH_W     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  // Position of the final emitted window on the stride grid.
  localparam int LAST_COL = (KSIZE - 1) + ((IMG_WIDTH - KSIZE) / STRIDE) * STRIDE;
  localparam int LAST_ROW = (KSIZE - 1) + ((IMG_HEIGHT - KSIZE) / STRIDE) * STRIDE;

  localparam logic [COL_W-1:0] COL_END   = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KSIZE - 1);
  localparam logic [COL_W-1:0] COL_LWIN  = COL_W'(LAST_COL);
  localparam logic [ROW_W-1:0] ROW_END   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KSIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LWIN  = ROW_W'(LAST_ROW);
  localparam logic [PH_W-1:0]  PH_END    = PH_W'(STRIDE - 1);

  // Index 0 is the newest pixel; higher indices are older.
  logic [PIXEL_W-1:0] line_buf [Z_DEPTH][BUF_LEN];
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [PH_W-1:0]    col_ph;
  logic [PH_W-1:0]    row_ph;
  logic               emit;
  logic               last_pos;

  // The phase counters are zero exactly on the stride grid once col/row reach
  // KSIZE-1; requiring col>=KSIZE-1 also excludes windows wrapping a row.
  always_comb begin
    emit     = in_valid && (col >= COL_FIRST) && (row >= ROW_FIRST) &&
               (col_ph == '0) && (row_ph == '0);
    last_pos = (col == COL_LWIN) && (row == ROW_LWIN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col          <= '0;
      row          <= '0;
      col_ph       <= '0;
      row_ph       <= '0;
      window_valid <= 1'b0;
      window_last  <= 1'b0;
      for (int z = 0; z < Z_DEPTH; z++)
        for (int i = 0; i < BUF_LEN; i++)
          line_buf[z][i] <= '0;
    end else begin
      window_valid <= emit;
      window_last  <= emit && last_pos;
      if (in_valid) begin
        for (int z = 0; z < Z_DEPTH; z++) begin
          line_buf[z][0] <= pixel_vector_in[z*PIXEL_W +: PIXEL_W];
          for (int i = 1; i < BUF_LEN; i++)
            line_buf[z][i] <= line_buf[z][i-1];
        end
        if (col == COL_END) begin
          col    <= '0;
          col_ph <= '0;
          if (row == ROW_END) begin
            row    <= '0;
            row_ph <= '0;
          end else begin
            row <= row + 1'b1;
            if (row >= ROW_FIRST)
              row_ph <= (row_ph == PH_END) ? '0 : row_ph + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
          if (col >= COL_FIRST)
            col_ph <= (col_ph == PH_END) ? '0 : col_ph + 1'b1;
        end
      end
    end
  end

  // Tap (ky,kx): ky=0 is the oldest row, kx=0 the oldest column.
  always_comb begin
    window = '0;
    for (int z = 0; z < Z_DEPTH; z++)
      for (int ky = 0; ky < KSIZE; ky++)
        for (int kx = 0; kx < KSIZE; kx++)
          window[((z*KSIZE + ky)*KSIZE + kx)*PIXEL_W +: PIXEL_W] =
            line_buf[z][(KSIZE-1-ky)*IMG_WIDTH + (KSIZE-1-kx)];
  end

endmodule

// File: rtl/conv_25d_stream.sv
// rtl/conv_25d_stream.sv - streaming 2.5-D convolution with bias, ReLU and frame-end marking
//
// Purpose: NUM_KERNELS parallel KSIZE x KSIZE x Z_DEPTH convolutions over a
// raster pixel stream; fixed 3-cycle latency from accepting edge to output.
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   in_valid            pixel_vector_in accepted at this edge
//   pixel_vector_in     Z_DEPTH unsigned 8-bit pixels
//   kernel              signed 8-bit taps, quasi-static
//   bias                signed 32-bit bias per kernel, quasi-static
//   relu_en             clamp negative results to 0, quasi-static
//   out_valid           pixel_vector_out holds a result
//   pixel_vector_out    signed 32-bit result per kernel at [k*32 +: 32]
//   out_last            last output of the frame

module conv_25d_stream
  import conv_pkg::*;
#(
  parameter int KSIZE       = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int Z_DEPTH     = 4,
  parameter int NUM_KERNELS = 2,
  parameter int STRIDE      = 1
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             in_valid,
  input  logic [PIXEL_W*Z_DEPTH-1:0]                       pixel_vector_in,
  input  logic [TAP_W*NUM_KERNELS*Z_DEPTH*KSIZE*KSIZE-1:0] kernel,
  input  logic [ACC_W*NUM_KERNELS-1:0]                     bias,
  input  logic                                             relu_en,
  output logic                                             out_valid,
  output logic [ACC_W*NUM_KERNELS-1:0]                     pixel_vector_out,
  output logic                                             out_last
);

  localparam int TAPS = KSIZE * KSIZE;

  logic                              window_valid;
  logic                              window_last;
  logic [PIXEL_W*Z_DEPTH*TAPS-1:0]   window;

  logic signed [PROD_W-1:0]          prod_q [NUM_KERNELS][Z_DEPTH][TAPS];
  logic                              s1_valid, s1_last, s1_relu;
  logic [ACC_W*NUM_KERNELS-1:0]      s1_bias;
  logic [ACC_W-1:0]                  sum_comb [NUM_KERNELS];
  logic [ACC_W-1:0]                  sum_q [NUM_KERNELS];
  logic                              s2_valid, s2_last, s2_relu;
  logic [ACC_W*NUM_KERNELS-1:0]      s2_bias;
  logic [ACC_W-1:0]                  res_comb [NUM_KERNELS];

  conv_window_buffer #(
    .KSIZE      (KSIZE),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .Z_DEPTH    (Z_DEPTH),
    .STRIDE     (STRIDE)
  ) u_window (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .pixel_vector_in (pixel_vector_in),
    .window_valid    (window_valid),
    .window_last     (window_last),
    .window          (window)
  );

  // S1: products. Bias and relu_en are sampled alongside the taps so that a
  // parameter change only affects windows entering S1 after it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
      s1_bias  <= '0;
      for (int k = 0; k < NUM_KERNELS; k++)
        for (int z = 0; z < Z_DEPTH; z++)
          for (int t = 0; t < TAPS; t++)
            prod_q[k][z][t] <= '0;
    end else begin
      s1_valid <= window_valid;
      s1_last  <= window_last;
      if (window_valid) begin
        s1_relu <= relu_en;
        s1_bias <= bias;
        for (int k = 0; k < NUM_KERNELS; k++)
          for (int z = 0; z < Z_DEPTH; z++)
            for (int ky = 0; ky < KSIZE; ky++)
              for (int kx = 0; kx < KSIZE; kx++)
                prod_q[k][z][ky*KSIZE + kx] <= pix_tap_mul(
                  window[((z*KSIZE + ky)*KSIZE + kx)*PIXEL_W +: PIXEL_W],
                  kernel[tap_offset(k, z, ky, kx, Z_DEPTH, KSIZE) +: TAP_W]);
      end
    end
  end

  // Sign-extended product sum; wraps modulo 2^32.
  always_comb begin
    for (int k = 0; k < NUM_KERNELS; k++) begin
      logic [ACC_W-1:0] acc;
      acc = '0;
      for (int z = 0; z < Z_DEPTH; z++)
        for (int t = 0; t < TAPS; t++)
          acc = acc + {{(ACC_W - PROD_W){prod_q[k][z][t][PROD_W-1]}}, prod_q[k][z][t]};
      sum_comb[k] = acc;
    end
  end

  // S2: per-kernel sums.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_relu  <= 1'b0;
      s2_bias  <= '0;
      for (int k = 0; k < NUM_KERNELS; k++)
        sum_q[k] <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) begin
        s2_relu <= s1_relu;
        s2_bias <= s1_bias;
        for (int k = 0; k < NUM_KERNELS; k++)
          sum_q[k] <= sum_comb[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_KERNELS; k++) begin
      res_comb[k] = sum_q[k] + s2_bias[k*ACC_W +: ACC_W];
      if (s2_relu && res_comb[k][ACC_W-1])
        res_comb[k] = '0;
    end
  end

  // S3: output register; the data holds between valid results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid        <= 1'b0;
      out_last         <= 1'b0;
      pixel_vector_out <= '0;
    end else begin
      out_valid <= s2_valid;
      out_last  <= s2_valid && s2_last;
      if (s2_valid)
        for (int k = 0; k < NUM_KERNELS; k++)
          pixel_vector_out[k*ACC_W +: ACC_W] <= res_comb[k];
    end
  end

endmodule

// File: tb/tb_conv_25d_stream.sv
// tb/tb_conv_25d_stream.sv - scoreboard bench for conv_25d_stream at stride 1 and 2

module tb_conv_25d_stream;

  localparam int K = 2, W = 4, H = 4, Z = 2, NK = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         relu_en = 1'b0;
  logic [15:0]  pixel_vector_in = '0;
  logic [127:0] kernel = {{8{8'hFF}}, {8{8'h01}}};
  logic [63:0]  bias = '0;
  logic         ov1, ol1, ov2, ol2;
  logic [63:0]  out1, out2;

  always #5 clock = ~clock;

  conv_25d_stream #(.KSIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .Z_DEPTH(Z),
                    .NUM_KERNELS(NK), .STRIDE(1)) u_s1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .pixel_vector_in(pixel_vector_in),
    .kernel(kernel), .bias(bias), .relu_en(relu_en),
    .out_valid(ov1), .pixel_vector_out(out1), .out_last(ol1));

  conv_25d_stream #(.KSIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .Z_DEPTH(Z),
                    .NUM_KERNELS(NK), .STRIDE(2)) u_s2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .pixel_vector_in(pixel_vector_in),
    .kernel(kernel), .bias(bias), .relu_en(relu_en),
    .out_valid(ov2), .pixel_vector_out(out2), .out_last(ol2));

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t q1[$], q2[$];
  exp_t e1, e2;
  int   obs1_k0[$], obs1_k1[$], obs2_k0[$];
  int   want[$], want_neg[$], want2[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   img[Z][H][W];
  int   mr = 0, mc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: direct convolution over the stored frame image.
  function automatic int conv_ref(input int k, input int r, input int c);
    int acc;
    logic signed [7:0] t;
    acc = 0;
    for (int z = 0; z < Z; z++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++) begin
          t = kernel[((k*Z + z)*K*K + ky*K + kx)*8 +: 8];
          acc += img[z][r-K+1+ky][c-K+1+kx] * int'(t);
        end
    acc += int'(bias[k*32 +: 32]);
    if (relu_en && acc < 0) acc = 0;
    return acc;
  endfunction

  task automatic model_accept(input logic [7:0] p0, input logic [7:0] p1);
    img[0][mr][mc] = int'(p0);
    img[1][mr][mc] = int'(p1);
    for (int s = 1; s <= 2; s++) begin
      if (mr >= K-1 && mc >= K-1 && (mc-K+1) % s == 0 && (mr-K+1) % s == 0) begin
        exp_t e;
        int a0, a1;
        a0 = conv_ref(0, mr, mc);
        a1 = conv_ref(1, mr, mc);
        e.data = {a1, a0};
        e.last = (mc + s > W-1) && (mr + s > H-1);
        e.cyc  = cyc + 4;
        if (s == 1) q1.push_back(e);
        else        q2.push_back(e);
      end
    end
    if (mc == W-1) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  task automatic accept(input logic [7:0] p0, input logic [7:0] p1);
    @(negedge clock);
    in_valid = 1'b1;
    pixel_vector_in = {p1, p0};
    model_accept(p0, p1);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
      pixel_vector_in = 16'($urandom);
    end
  endtask

  task automatic ramp_frame(input bit toggle);
    for (int i = 0; i < W*H; i++) begin
      accept(8'(i), 8'(i));
      if (toggle) gap(1);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_list(input string name, input int got[$], input int wl[$]);
    int bad;
    bad = -1;
    checks++;
    if (got.size() < wl.size()) bad = got.size();
    else foreach (wl[i]) if (bad < 0 && got[i] != wl[i]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s idx=%0d got=%0d want=%0d (received %0d values)", name, bad,
               (bad < got.size()) ? got[bad] : 0, wl[bad], got.size());
    end
  endtask

  task automatic clear_obs();
    obs1_k0.delete();
    obs1_k1.delete();
    obs2_k0.delete();
  endtask

  always @(negedge clock) begin
    if (reset && ov1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL s1_unexpected data=%h last=%0b cyc=%0d", out1, ol1, cyc);
      end else begin
        e1 = q1.pop_front();
        if (out1 !== e1.data || ol1 !== e1.last || cyc != e1.cyc) begin
          errors++;
          $display("FAIL s1_out got data=%h last=%0b cyc=%0d want data=%h last=%0b cyc=%0d",
                   out1, ol1, cyc, e1.data, e1.last, e1.cyc);
        end
      end
      obs1_k0.push_back(int'($signed(out1[31:0])));
      obs1_k1.push_back(int'($signed(out1[63:32])));
    end
  end

  always @(negedge clock) begin
    if (reset && ov2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL s2_unexpected data=%h last=%0b cyc=%0d", out2, ol2, cyc);
      end else begin
        e2 = q2.pop_front();
        if (out2 !== e2.data || ol2 !== e2.last || cyc != e2.cyc) begin
          errors++;
          $display("FAIL s2_out got data=%h last=%0b cyc=%0d want data=%h last=%0b cyc=%0d",
                   out2, ol2, cyc, e2.data, e2.last, e2.cyc);
        end
      end
      obs2_k0.push_back(int'($signed(out2[31:0])));
    end
  end

  initial begin
    #1;
    check("reset_flags", {60'd0, ov1, ol1, ov2, ol2}, 64'd0);
    check("reset_out1", out1, 64'd0);
    check("reset_out2", out2, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Continuous ramp, stride 1 and 2
    clear_obs();
    ramp_frame(0);
    gap(6);
    want = '{20, 28, 36, 52, 60, 68, 84, 92, 100};
    want_neg.delete();
    foreach (want[i]) want_neg.push_back(-want[i]);
    check_list("ramp_k0", obs1_k0, want);
    check_list("ramp_k1", obs1_k1, want_neg);
    want2 = '{20, 36, 84, 100};
    check_list("stride2_k0", obs2_k0, want2);

    // in_valid toggling every other cycle
    clear_obs();
    ramp_frame(1);
    gap(6);
    check_list("toggle_k0", obs1_k0, want);

    // Bias and ReLU
    bias = {32'd30, 32'd5};
    relu_en = 1'b1;
    clear_obs();
    ramp_frame(0);
    gap(6);
    want2 = '{25, 33, 41};
    check_list("relu_k0", obs1_k0, want2);
    want2 = '{10, 2, 0};
    check_list("relu_k1", obs1_k1, want2);
    bias = '0;
    relu_en = 1'b0;

    // Reset mid-frame with results in flight
    for (int i = 0; i < 10; i++) accept(8'(i), 8'(i));
    @(negedge clock);
    in_valid = 1'b0;
    #2;
    check("pre_reset_valid", {63'd0, ov1}, 64'd1);
    reset = 1'b0;
    #1;
    check("async_reset_flags", {60'd0, ov1, ol1, ov2, ol2}, 64'd0);
    check("async_reset_out", out1, 64'd0);
    q1.delete();
    q2.delete();
    mr = 0;
    mc = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clear_obs();
    ramp_frame(0);
    gap(6);
    check_list("after_reset_k0", obs1_k0, want);

    // Back-to-back frames
    clear_obs();
    ramp_frame(0);
    ramp_frame(0);
    gap(6);
    want2.delete();
    repeat (2) foreach (want[i]) want2.push_back(want[i]);
    check_list("b2b_k0", obs1_k0, want2);

    // Random frames, kernels, bias, relu and input gaps
    for (int f = 0; f < 5; f++) begin
      kernel  = {$urandom, $urandom, $urandom, $urandom};
      bias    = (f % 2 == 0) ? {$urandom, $urandom} : 64'd0;
      relu_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < W*H; i++) begin
        accept(8'($urandom), 8'($urandom));
        if ($urandom_range(0, 9) < 3) gap($urandom_range(1, 3));
      end
      gap(6);
    end

    check("s1_drained", 64'(q1.size()), 64'd0);
    check("s2_drained", 64'(q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_25d_stream.md
# conv_25d_stream

Streaming 2.5-D convolution layer: accepts one Z_DEPTH-channel pixel vector per valid cycle in raster order and applies NUM_KERNELS kernels of KSIZE x KSIZE x Z_DEPTH. Each output vector carries one signed 32-bit result per kernel, with optional per-kernel bias and ReLU. It succeeds the fixed-latency, always-streaming 2.5-D convolution: it adds input/output valid qualification, suppression of row-wrap windows, stride, bias and end-of-frame marking. It sits between the pixel source (or previous layer) and the pooling/output stage.

## Interface
- KSIZE, 3, kernel height and width (>=2)
- IMG_WIDTH, 8, pixels per row
- IMG_HEIGHT, 8, rows per frame
- Z_DEPTH, 4, input channels
- NUM_KERNELS, 2, kernels evaluated in parallel
- STRIDE, 1, output stride in x and y (>=1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- in_valid  in  1  pixel_vector_in accepted at this edge
- pixel_vector_in  in  8*Z_DEPTH  unsigned pixels; channel z at [z*8 +: 8]
- kernel  in  8*NUM_KERNELS*Z_DEPTH*KSIZE*KSIZE  signed taps; tap (k,z,ky,kx) at [((k*Z_DEPTH+z)*KSIZE*KSIZE + ky*KSIZE + kx)*8 +: 8]; quasi-static
- bias  in  32*NUM_KERNELS  signed bias per kernel at [k*32 +: 32]; quasi-static
- relu_en  in  1  clamp negative results to 0; quasi-static
- out_valid  out  1  pixel_vector_out holds a valid result
- pixel_vector_out  out  32*NUM_KERNELS  signed result for kernel k at [k*32 +: 32]
- out_last  out  1  with out_valid: last output of the frame

## Operation
- Window buffer per channel: (KSIZE-1)*IMG_WIDTH+KSIZE entries, shifts only on in_valid. Tap ky=0 is the top (oldest) row, kx=0 the leftmost (oldest) column.
- Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the pixel being accepted. They advance on in_valid only. col wraps to 0 and row increments. At the last pixel of the frame both wrap to 0 with no idle cycle.
- A window is emitted when the accepted pixel satisfies col>=KSIZE-1, row>=KSIZE-1, (col-(KSIZE-1))%STRIDE==0 and (row-(KSIZE-1))%STRIDE==0. Implement the stride test with phase counters, not division.
- Windows that straddle a row boundary are never emitted.
- Arithmetic: pixel is zero-extended to 9 bits and multiplied by the signed tap, giving a signed 17-bit product. Products are sign-extended to 32 bits and summed over z, ky, kx. bias[k] is then added. All addition wraps modulo 2^32; there is no saturation.
- ReLU: when relu_en=1, a result with bit 31 set becomes 0.
- out_last is asserted with the output produced by the last emitted window of the frame.
- While in_valid=0, the buffer and counters hold. Results already in flight keep draining.
- Reset values: out_valid=0, out_last=0, pixel_vector_out=0, counters=0, pipeline valid tags=0, buffer=0.

## Timing
- Pipeline stages:
  - S0: window registers update at the accepting edge n.
  - S1: products registered at edge n+1.
  - S2: per-kernel sums registered at edge n+2.
  - S3: bias, ReLU and output registered at edge n+3.
- out_valid rises after edge n+3. Latency is fixed at 3 cycles regardless of in_valid gaps.
- Throughput is one output per clock when input is continuous.
- Reset asserted mid-frame clears all valid tags immediately. Nothing in flight is emitted, and the next accepted pixel is treated as (row 0, col 0).
- A kernel, bias or relu_en change takes effect on windows entering S1 after the change.

## Structure
- Shared package conv_pkg holds:
  - PIXEL_W=8, TAP_W=8, PROD_W=17, ACC_W=32;
  - a function for tap bit offset;
  - a function for buffer length.
- Sub-module conv_window_buffer holds the per-channel shift buffer, the row/col/stride counters, and produces window_valid/window_last plus the flattened window. The top level holds the S1–S3 arithmetic pipeline.

## Test plan
All scenarios use KSIZE=2, IMG_WIDTH=4, IMG_HEIGHT=4 and Z_DEPTH=2. Input is a raster ramp: the pixel at (r,c) is r*4+c on both channels, with in_valid continuous. Kernel 0 is all +1 and kernel 1 is all 0xFF (-1). bias=0 and relu_en=0 unless stated.
1. STRIDE=1 basic -> outputs for kernel 0 are 20, 28, 36, then 52, 60, 68, then 84, 92, 100. Kernel 1 gives the negatives. out_valid is high 3 cycles after pixel 5 is accepted. out_last is set on the 100 output only; the col=3 row-wrap window produces no output.
2. Same as scenario 1 with in_valid toggled every other cycle -> identical value sequence. Each output appears exactly 3 cycles after its completing pixel.
3. STRIDE=2 -> only 20, 36, 84, 100 are produced, with out_last on 100.
4. relu_en=1 with bias[0]=5 and bias[1]=30 -> kernel 0 gives 25, 33, 41, …. Kernel 1 gives 10, 2, 0, … (first three windows).
5. Reset asserted 2 cycles after the first output, then the frame restarted -> out_valid drops asynchronously. The restarted frame yields 20 again as the first output.
6. Back-to-back frames with no gap -> the second frame's first output is 20, with no stale window mixing across the frame boundary.
